// File: rtl/processinho_core.sv
// Processinho: a minimal accumulator CPU with handshaked instruction and data ports.
// Each instruction goes FETCH -> DECODE (-> MEM for memory operands) and back to FETCH.
module processinho_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [ADDR_W+3:0]   imem_rdata,
  input  logic                imem_ack,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W-1:0]   dmem_rdata,
  input  logic                dmem_ack,
  input  logic [DATA_W-1:0]   data_bus_in,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  output logic [DATA_W-1:0]   acc,
  output logic [ADDR_W-1:0]   pc,
  output logic [2:0]          state,
  output logic                halted
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MEM    = 3'd2,
    HALT   = 3'd3
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_IN  = 4'hC;
  localparam logic [3:0] OP_OUT = 4'hD;
  localparam logic [3:0] OP_NOT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pc_reg, pc_next;
  logic [ADDR_W+3:0]   ir_reg, ir_next;
  logic [DATA_W-1:0]   acc_reg, acc_next;
  logic                acc_load;
  logic                z_reg;
  logic                c_reg, c_next;
  logic [DATA_W-1:0]   out_data_reg, out_data_next;
  logic                out_valid_reg, out_valid_next;

  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   operand;
  logic [DATA_W:0]     sum_ext;
  logic                is_mem_op;

  assign opcode    = ir_reg[ADDR_W+3:ADDR_W];
  assign operand   = ir_reg[ADDR_W-1:0];
  assign sum_ext   = {1'b0, acc_reg} + {1'b0, dmem_rdata};
  assign is_mem_op = (opcode != 4'h0) && !opcode[3];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:   state_next = imem_ack ? DECODE : FETCH;
      DECODE: begin
        if (opcode == OP_HLT)  state_next = HALT;
        else if (is_mem_op)    state_next = MEM;
        else                   state_next = FETCH;
      end
      MEM:     state_next = dmem_ack ? FETCH : MEM;
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    pc_next        = pc_reg;
    ir_next        = ir_reg;
    acc_next       = acc_reg;
    acc_load       = 1'b0;
    c_next         = c_reg;
    out_data_next  = out_data_reg;
    out_valid_next = 1'b0;
    case (state_reg)
      FETCH: begin
        if (imem_ack) begin
          ir_next = imem_rdata;
          pc_next = pc_reg + ADDR_W'(1);
        end
      end
      DECODE: begin
        case (opcode)
          OP_LDI: begin acc_next = DATA_W'(operand); acc_load = 1'b1; end
          OP_JMP: pc_next = operand;
          OP_JZ:  if (z_reg) pc_next = operand;
          OP_JC:  if (c_reg) pc_next = operand;
          OP_IN:  begin acc_next = data_bus_in; acc_load = 1'b1; end
          OP_OUT: begin out_data_next = acc_reg; out_valid_next = 1'b1; end
          OP_NOT: begin acc_next = ~acc_reg; acc_load = 1'b1; end
          default: ;
        endcase
      end
      MEM: begin
        // STA needs no datapath update: the write completes on the memory side at ack.
        if (dmem_ack) begin
          case (opcode)
            OP_LDA: begin acc_next = dmem_rdata; acc_load = 1'b1; end
            OP_ADD: begin {c_next, acc_next} = sum_ext; acc_load = 1'b1; end
            OP_SUB: begin
              acc_next = acc_reg - dmem_rdata;
              c_next   = acc_reg < dmem_rdata;
              acc_load = 1'b1;
            end
            OP_AND: begin acc_next = acc_reg & dmem_rdata; acc_load = 1'b1; end
            OP_OR:  begin acc_next = acc_reg | dmem_rdata; acc_load = 1'b1; end
            OP_XOR: begin acc_next = acc_reg ^ dmem_rdata; acc_load = 1'b1; end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_reg        <= '0;
      ir_reg        <= '0;
      acc_reg       <= '0;
      z_reg         <= 1'b0;
      c_reg         <= 1'b0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      pc_reg        <= pc_next;
      ir_reg        <= ir_next;
      acc_reg       <= acc_next;
      c_reg         <= c_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      if (acc_load) z_reg <= (acc_next == '0);
    end
  end

  // Requests are gated by reset so an in-flight access is dropped the moment reset rises.
  assign imem_req   = (state_reg == FETCH) && !reset;
  assign dmem_req   = (state_reg == MEM) && !reset;
  assign dmem_we    = dmem_req && (opcode == OP_STA);
  assign imem_addr  = pc_reg;
  assign dmem_addr  = operand;
  assign dmem_wdata = acc_reg;
  assign out_data   = out_data_reg;
  assign out_valid  = out_valid_reg;
  assign acc        = acc_reg;
  assign pc         = pc_reg;
  assign state      = state_reg;
  assign halted     = (state_reg == HALT);

endmodule

// File: tb/tb_processinho_core.sv
// Randomized and directed bench for processinho_core against an instruction-level model.
module tb_processinho_core;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       imem_req, imem_ack;
  logic [3:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       dmem_req, dmem_we, dmem_ack;
  logic [3:0] dmem_addr;
  logic [7:0] dmem_wdata, dmem_rdata;
  logic [7:0] data_bus_in, out_data, acc;
  logic       out_valid, halted;
  logic [3:0] pc;
  logic [2:0] state;

  processinho_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .data_bus_in(data_bus_in),
    .out_data(out_data), .out_valid(out_valid), .acc(acc), .pc(pc), .state(state),
    .halted(halted)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // memory side seen by the DUT
  logic [7:0] prog [16];
  logic [7:0] phys [16];
  int iwait, dwait, idly_lo, idly_hi, ddly_lo, ddly_hi;
  bit spur, rand_din;

  // instruction-level reference model
  int m_pc, m_acc, m_out, m_z, m_c;
  int m_dmem [16];
  int cur_op, acc_before, mem_addr, prev_state;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ins(input int op, input int opd);
    logic [3:0] o, a;
    o = op[3:0];
    a = opd[3:0];
    return {o, a};
  endfunction

  // Executes the instruction at the model PC in one step, using the bus input value
  // that the core will sample at the end of DECODE.
  task automatic model_step();
    int op, opd, mv, s;
    op = int'(prog[m_pc][7:4]);
    opd = int'(prog[m_pc][3:0]);
    mv = m_dmem[opd];
    cur_op = op;
    mem_addr = opd;
    acc_before = m_acc;
    m_pc = (m_pc + 1) % 16;
    case (op)
      1: m_acc = mv;
      2: m_dmem[opd] = m_acc;
      3: begin s = m_acc + mv; m_c = (s > 255); m_acc = s % 256; end
      4: begin m_c = (m_acc < mv); m_acc = (m_acc - mv + 256) % 256; end
      5: m_acc = m_acc & mv;
      6: m_acc = m_acc | mv;
      7: m_acc = m_acc ^ mv;
      8: m_acc = opd;
      9: m_pc = opd;
      10: if (m_z != 0) m_pc = opd;
      11: if (m_c != 0) m_pc = opd;
      12: m_acc = int'(data_bus_in);
      13: m_out = m_acc;
      14: m_acc = 255 - m_acc;
      default: ;
    endcase
    if (op == 1 || (op >= 3 && op <= 8) || op == 12 || op == 14) m_z = (m_acc == 0);
  endtask

  task automatic cycle();
    int st;
    @(negedge clock);
    st = int'(state);
    check("state_legal", state <= 3'd3, 1'b1);
    if ((prev_state == 1 || prev_state == 2) && (st == 0 || st == 3)) begin
      check("ret_state", st, (cur_op == 15) ? 3 : 0);
      check("ret_acc", acc, m_acc);
      check("ret_pc", pc, m_pc);
      check("ret_out", out_data, m_out);
      $display("retire op=%h pc=%h acc=%h out=%h", cur_op, pc, acc, out_data);
    end
    check("out_valid", out_valid, (prev_state == 1 && cur_op == 13));
    if (st == 1) begin
      check("dec_noreq", {imem_req, dmem_req}, 2'b00);
      model_step();
    end else if (st == 0) begin
      check("fetch_bus", {imem_req, dmem_req, halted}, 3'b100);
      check("fetch_addr", imem_addr, m_pc);
      check("fetch_acc", acc, m_acc);
    end else if (st == 2) begin
      check("mem_bus", {imem_req, dmem_req, dmem_we}, {2'b01, cur_op == 2});
      check("mem_addr", dmem_addr, mem_addr);
      check("mem_acc_hold", acc, acc_before);
      if (cur_op == 2) check("mem_wdata", dmem_wdata, acc_before);
    end else if (st == 3) begin
      check("halt_bus", {imem_req, dmem_req, halted}, 3'b001);
      check("halt_hold", {acc, pc}, {m_acc[7:0], pc});
      check("halt_acc", acc, m_acc);
    end
    // instruction memory responder
    if (imem_req) begin
      if (iwait == 0) begin
        imem_ack = 1'b1;
        imem_rdata = prog[imem_addr];
        iwait = $urandom_range(idly_hi, idly_lo);
      end else begin
        imem_ack = 1'b0;
        imem_rdata = 8'($urandom);
        iwait--;
      end
    end else begin
      imem_ack = spur && ($urandom_range(0, 2) == 0);
      imem_rdata = 8'($urandom);
    end
    // data memory responder
    if (dmem_req) begin
      if (dwait == 0) begin
        dmem_ack = 1'b1;
        if (dmem_we) phys[dmem_addr] = dmem_wdata;
        else dmem_rdata = phys[dmem_addr];
        dwait = $urandom_range(ddly_hi, ddly_lo);
      end else begin
        dmem_ack = 1'b0;
        dmem_rdata = 8'($urandom);
        dwait--;
      end
    end else begin
      dmem_ack = spur && ($urandom_range(0, 2) == 0);
      dmem_rdata = 8'($urandom);
    end
    if (rand_din && st == 0) data_bus_in = 8'($urandom);
    prev_state = st;
  endtask

  // Called at a falling edge; raises reset mid-cycle so its asynchronous effect is visible.
  task automatic do_reset();
    #2 reset = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    check("rst_state", state, 3'd0);
    check("rst_pc", pc, 4'd0);
    check("rst_acc", acc, 8'd0);
    check("rst_out", {out_data, out_valid}, 9'd0);
    check("rst_halted", halted, 1'b0);
    check("rst_req", {imem_req, dmem_req}, 2'b00);
    @(negedge clock);
    reset = 1'b0;
    m_pc = 0; m_acc = 0; m_out = 0; m_z = 0; m_c = 0;
    cur_op = 0; prev_state = 0;
    for (int i = 0; i < 16; i++) m_dmem[i] = int'(phys[i]);
    iwait = $urandom_range(idly_hi, idly_lo);
    dwait = $urandom_range(ddly_hi, ddly_lo);
  endtask

  task automatic run(input int max_cycles);
    int hc;
    hc = 0;
    for (int i = 0; i < max_cycles && hc < 3; i++) begin
      cycle();
      if (halted) hc++;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      prog[i] = 8'h00;
      phys[i] = 8'h00;
    end
  endtask

  task automatic set_delays(input int il, input int ih, input int dl, input int dh, input bit sp);
    idly_lo = il; idly_hi = ih; ddly_lo = dl; ddly_hi = dh; spur = sp;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    imem_ack = 0; dmem_ack = 0; imem_rdata = 0; dmem_rdata = 0; data_bus_in = 0;
    rand_din = 1'b1;
    set_delays(0, 2, 0, 2, 1'b0);
    clear_mem();
    @(negedge clock);

    // ADD overflow into carry, Z clear on nonzero result
    clear_mem();
    prog[0] = ins(8, 5);  prog[1] = ins(3, 9);  prog[2] = ins(10, 15);
    prog[3] = ins(3, 9);  prog[4] = ins(11, 6); prog[5] = ins(15, 0);
    prog[6] = ins(13, 0); prog[7] = ins(15, 0);
    phys[9] = 8'd250;
    do_reset();
    run(200);
    check("add_halted", halted, 1'b1);
    check("add_acc", acc, 8'd249);
    check("add_out", out_data, 8'd249);
    check("add_pc", pc, 4'd8);

    // SUB to zero sets Z, clears C; taken and not-taken branches; PC wrap 15->0
    clear_mem();
    prog[0] = ins(8, 3);   prog[1] = ins(4, 2);   prog[2] = ins(10, 12);
    prog[12] = ins(8, 1);  prog[13] = ins(10, 0); prog[14] = ins(11, 0);
    prog[15] = ins(15, 0);
    phys[2] = 8'd3;
    do_reset();
    run(200);
    check("sub_halted", halted, 1'b1);
    check("sub_acc", acc, 8'd1);
    check("sub_pc", pc, 4'd0);

    // slow handshakes with spurious acks outside the owning state
    clear_mem();
    set_delays(3, 3, 2, 2, 1'b1);
    prog[0] = ins(8, 7); prog[1] = ins(3, 3); prog[2] = ins(13, 0); prog[3] = ins(15, 0);
    phys[3] = 8'd4;
    do_reset();
    run(300);
    check("slow_halted", halted, 1'b1);
    check("slow_out", out_data, 8'd11);

    // IN / OUT / STA path
    clear_mem();
    set_delays(0, 1, 0, 1, 1'b1);
    rand_din = 1'b0;
    data_bus_in = 8'hA5;
    prog[0] = ins(12, 0); prog[1] = ins(13, 0); prog[2] = ins(2, 7); prog[3] = ins(15, 0);
    do_reset();
    run(200);
    check("io_halted", halted, 1'b1);
    check("io_out", out_data, 8'hA5);
    check("io_mem7", phys[7], 8'hA5);
    rand_din = 1'b1;

    // sixteen NOPs: fetch address walks 15 -> 0
    clear_mem();
    set_delays(0, 0, 0, 0, 1'b0);
    do_reset();
    n = 0;
    while (!(state == 3'd0 && pc == 4'd15) && n < 100) begin cycle(); n++; end
    check("nop_reach15", pc, 4'd15);
    n = 0;
    while (state != 3'd1 && n < 20) begin cycle(); n++; end
    n = 0;
    while (state != 3'd0 && n < 20) begin cycle(); n++; end
    check("nop_wrap", imem_addr, 4'd0);

    // reset while a store is waiting for its ack
    clear_mem();
    set_delays(0, 0, 6, 6, 1'b0);
    prog[0] = ins(8, 9); prog[1] = ins(2, 5); prog[2] = ins(15, 0);
    phys[5] = 8'h33;
    do_reset();
    n = 0;
    while (!dmem_req && n < 50) begin cycle(); n++; end
    check("mid_mem_seen", dmem_req, 1'b1);
    do_reset();
    check("mid_mem_nowrite", phys[5], 8'h33);
    set_delays(0, 1, 0, 1, 1'b0);
    iwait = 0; dwait = 0;
    run(100);
    check("mid_mem_rerun", phys[5], 8'h09);
    check("mid_mem_halted", halted, 1'b1);

    // randomized programs
    for (int p = 0; p < 6; p++) begin
      set_delays(0, 3, 0, 3, 1'b1);
      for (int i = 0; i < 16; i++) begin
        prog[i] = 8'($urandom);
        if (prog[i][7:4] == 4'hF && $urandom_range(0, 3) != 0) prog[i] = 8'h00;
        phys[i] = 8'($urandom);
      end
      do_reset();
      run(300);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
